// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 datapath: FSM states, flag bit positions
// and binary16 special-value constants.
package fma16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIV,
    ROUND,
    DONE
  } state_t;

  // Flag vector layout: {NV, DZ, OF, UF, NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] INF     = 16'h7C00;
  localparam logic [15:0] MAXNORM = 16'h7BFF;
  localparam int          BIAS    = 15;

endpackage

// File: rtl/fma16_div_step.sv
// Combinational restoring-division step: retires BPC quotient bits from the
// running remainder against an 11-bit divisor.
module fma16_div_step #(
  parameter int BPC = 1
) (
  input  logic [11:0]    rem_i,
  input  logic [10:0]    div_i,
  output logic [11:0]    rem_o,
  output logic [BPC-1:0] q_o
);

  logic [11:0] r;
  logic [12:0] trial;

  // The remainder stays below the divisor (< 2^11), so the left shift never drops a set bit.
  always_comb begin
    r     = rem_i;
    trial = '0;
    q_o   = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      trial = {1'b0, r} - {2'b00, div_i};
      if (!trial[12]) begin
        q_o[BPC-1-i] = 1'b1;
        r            = trial[11:0];
      end
      r = {r[10:0], 1'b0};
    end
    rem_o = r;
  end

endmodule

// File: rtl/fma16_fdiv_iter.sv
// Iterative binary16 divider (x / y) with valid/ready ports, DAZ inputs and flush-to-zero outputs.
// Rounding: FDIV16_RNE_EN selects round-to-nearest-even; otherwise round toward zero.
module fma16_fdiv_iter #(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);
  import fma16_pkg::*;

  localparam int unsigned NCYC = (13 + BPC - 1) / BPC;
  localparam int unsigned QW   = NCYC * BPC;

  state_t             state_q, state_d;
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic               sign_q, sign_d;
  logic signed [6:0]  e_q, e_d;
  logic [10:0]        my_q, my_d;
  logic [11:0]        rem_q, rem_d;
  logic [QW-1:0]      q_q, q_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic [11:0]        step_rem;
  logic [BPC-1:0]     step_q;

  fma16_div_step #(.BPC(BPC)) u_step (
    .rem_i (rem_q),
    .div_i (my_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand classification
  logic [4:0]  ex, ey;
  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sgn;
  logic        is_special;
  logic [15:0] spec_res;
  logic [4:0]  spec_fl;

  always_comb begin
    ex         = x_q[14:10];
    ey         = y_q[14:10];
    x_nan      = (ex == 5'h1F) && (x_q[9:0] != '0);
    y_nan      = (ey == 5'h1F) && (y_q[9:0] != '0);
    x_inf      = (ex == 5'h1F) && (x_q[9:0] == '0);
    y_inf      = (ey == 5'h1F) && (y_q[9:0] == '0);
    x_zero     = (ex == '0);
    y_zero     = (ey == '0);
    sgn        = x_q[15] ^ y_q[15];
    is_special = 1'b1;
    spec_res   = '0;
    spec_fl    = '0;
    if (x_nan || y_nan) begin
      spec_res         = QNAN;
      spec_fl[FLAG_NV] = 1'b1;
    end else if ((x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_res         = QNAN;
      spec_fl[FLAG_NV] = 1'b1;
    end else if (!x_inf && y_zero) begin
      spec_res         = {sgn, INF[14:0]};
      spec_fl[FLAG_DZ] = 1'b1;
    end else if (x_inf) begin
      spec_res = {sgn, INF[14:0]};
    end else if (x_zero || y_inf) begin
      spec_res = {sgn, 15'h0000};
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalise, round and range-check the quotient
  logic [QW:0]        qx;
  logic [12:0]        q13;
  logic               low_st, g, st, inc;
  logic [10:0]        sig, sig_r;
  logic [11:0]        sum;
  logic signed [6:0]  en, er;
  logic [15:0]        rnd_res;
  logic [4:0]         rnd_fl;

  always_comb begin
    qx     = {q_q, 1'b0};
    q13    = qx[QW -: 13];
    low_st = (|qx[QW-13:0]) | (|rem_q);
    if (q13[12]) begin
      sig = q13[12:2];
      g   = q13[1];
      st  = q13[0] | low_st;
      en  = e_q;
    end else begin
      sig = q13[11:1];
      g   = q13[0];
      st  = low_st;
      en  = e_q - 7'sd1;
    end
`ifdef FDIV16_RNE_EN
    inc = g & (st | sig[0]);
`else
    inc = 1'b0;
`endif
    sum    = {1'b0, sig} + {11'h000, inc};
    sig_r  = sum[11] ? sum[11:1] : sum[10:0];
    er     = sum[11] ? (en + 7'sd1) : en;
    rnd_fl = '0;
    rnd_fl[FLAG_NX] = g | st;
    if (er >= 7'sd31) begin
`ifdef FDIV16_RNE_EN
      rnd_res = {sign_q, INF[14:0]};
`else
      rnd_res = {sign_q, MAXNORM[14:0]};
`endif
      rnd_fl[FLAG_OF] = 1'b1;
      rnd_fl[FLAG_NX] = 1'b1;
    end else if (er <= 7'sd0) begin
      rnd_res         = {sign_q, 15'h0000};
      rnd_fl[FLAG_UF] = 1'b1;
      rnd_fl[FLAG_NX] = 1'b1;
    end else begin
      rnd_res = {sign_q, er[4:0], sig_r[9:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sign_d      = sign_q;
    e_d         = e_q;
    my_d        = my_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d = sgn;
        e_d    = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 7'(BIAS);
        my_d   = {1'b1, y_q[9:0]};
        rem_d  = {2'b01, x_q[9:0]};
        q_d    = '0;
        cnt_d  = '0;
        if (is_special) begin
          result_d = spec_res;
          flags_d  = spec_fl;
          state_d  = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = step_rem;
        q_d   = {q_q[QW-BPC-1:0], step_q};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NCYC - 1)) state_d = ROUND;
      end
      ROUND: begin
        result_d    = rnd_res;
        flags_d     = rnd_fl;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Special results arrive in DONE with out_valid still low; raise it one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sign_q      <= 1'b0;
      e_q         <= '0;
      my_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sign_q      <= sign_d;
      e_q         <= e_d;
      my_q        <= my_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fma16_fdiv_iter.sv
// Scoreboard bench for fma16_fdiv_iter: expected results queued at issue, compared at output.
module tb_fma16_fdiv_iter;

  localparam int BPC      = 1;
  localparam int NORM_LAT = 2 + (13 + BPC - 1) / BPC;
  localparam int SPEC_LAT = 2;

`ifdef FDIV16_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_DZ = 5'b01000;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [4:0] F_UF = 5'b00010;
  localparam logic [4:0] F_NX = 5'b00001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [4:0]  flags;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fma16_fdiv_iter #(.BPC(BPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x_in),
    .y         (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Called at #1 after the accept edge; waits for output, checks, holds, then handshakes.
  task automatic collect(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    asserts++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: queue size=0 required >0");
      fails++;
    end else begin
      e = sb.pop_front();
      if (out_valid !== 1'b1) begin
        $display("FAIL %s_timeout: out_valid=%b after %0d cycles required 1", e.name, out_valid, n);
        fails++;
      end else begin
        asserts++;
        if (result !== e.res) begin
          $display("FAIL %s_result: got %h required %h", e.name, result, e.res);
          fails++;
        end
        asserts++;
        if (flags !== e.fl) begin
          $display("FAIL %s_flags: got %b required %b", e.name, flags, e.fl);
          fails++;
        end
        asserts++;
        if (n != e.lat) begin
          $display("FAIL %s_latency: got %0d required %0d", e.name, n, e.lat);
          fails++;
        end
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          asserts++;
          if (result !== e.res || flags !== e.fl || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL %s_hold%0d: res=%h fl=%b ov=%b ir=%b required res=%h fl=%b ov=1 ir=0",
                     e.name, i, result, flags, out_valid, in_ready, e.res, e.fl);
            fails++;
          end
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    asserts++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL handshake: out_valid=%b in_ready=%b required 0 and 1", out_valid, in_ready);
      fails++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [4:0] fl, input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    asserts++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
      fails++;
    end
    e.name = name; e.res = res; e.fl = fl; e.lat = lat;
    sb.push_back(e);
    x_in = a; y_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 5'b0) begin
      $display("FAIL reset_state: ov=%b res=%h fl=%b required 0 0000 00000", out_valid, result, flags);
      fails++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
      fails++;
    end
  endtask

  task automatic test_normal();
    run_op("one_div_one",   16'h3C00, 16'h3C00, 16'h3C00, 5'b0, NORM_LAT);
    run_op("one_third",     16'h3C00, 16'h4200, 16'h3555, F_NX, NORM_LAT);
    run_op("two_thirds",    16'h4000, 16'h4200, 16'h3955, F_NX, NORM_LAT);
    run_op("five_thirds",   16'h4500, 16'h4200, RNE ? 16'h3EAB : 16'h3EAA, F_NX, NORM_LAT);
    run_op("neg_two",       16'hC000, 16'h3C00, 16'hC000, 5'b0, NORM_LAT);
    run_op("four_by_two",   16'h4400, 16'h4000, 16'h4000, 5'b0, NORM_LAT);
    run_op("neg_third",     16'h3C00, 16'hC200, 16'hB555, F_NX, NORM_LAT);
  endtask

  task automatic test_special();
    run_op("div_by_zero",   16'h3C00, 16'h0000, 16'h7C00, F_DZ, SPEC_LAT);
    run_op("zero_by_zero",  16'h0000, 16'h0000, 16'h7E00, F_NV, SPEC_LAT);
    run_op("nan_operand",   16'h7E00, 16'h3C00, 16'h7E00, F_NV, SPEC_LAT);
    run_op("nan_divisor",   16'h3C00, 16'h7C01, 16'h7E00, F_NV, SPEC_LAT);
    run_op("inf_by_inf",    16'h7C00, 16'h7C00, 16'h7E00, F_NV, SPEC_LAT);
    run_op("neg_by_zero",   16'hBC00, 16'h0000, 16'hFC00, F_DZ, SPEC_LAT);
    run_op("inf_by_zero",   16'h7C00, 16'h0000, 16'h7C00, 5'b0, SPEC_LAT);
    run_op("inf_by_neg",    16'h7C00, 16'hC000, 16'hFC00, 5'b0, SPEC_LAT);
    run_op("fin_by_inf",    16'h3C00, 16'h7C00, 16'h0000, 5'b0, SPEC_LAT);
    run_op("negzero_num",   16'h8000, 16'h3C00, 16'h8000, 5'b0, SPEC_LAT);
    run_op("daz_dividend",  16'h0200, 16'h3C00, 16'h0000, 5'b0, SPEC_LAT);
    run_op("daz_divisor",   16'h3C00, 16'h0200, 16'h7C00, F_DZ, SPEC_LAT);
  endtask

  task automatic test_range();
    run_op("overflow",      16'h7BFF, 16'h3800, RNE ? 16'h7C00 : 16'h7BFF, F_OF | F_NX, NORM_LAT);
    run_op("neg_overflow",  16'hFBFF, 16'h3800, RNE ? 16'hFC00 : 16'hFBFF, F_OF | F_NX, NORM_LAT);
    run_op("underflow",     16'h0400, 16'h4000, 16'h0000, F_UF | F_NX, NORM_LAT);
    run_op("neg_underflow", 16'h8400, 16'h4000, 16'h8000, F_UF | F_NX, NORM_LAT);
  endtask

  task automatic test_backpressure();
    exp_t e;
    e.name = "bp_first"; e.res = 16'h3555; e.fl = F_NX; e.lat = NORM_LAT;
    sb.push_back(e);
    x_in = 16'h3C00; y_in = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep a competing request pending for the whole stall; it must not be taken early.
    x_in = 16'h4000; y_in = 16'h3C00;
    collect(10);
    e.name = "bp_second"; e.res = 16'h4000; e.fl = 5'b0; e.lat = NORM_LAT;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    asserts++;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready);
      fails++;
    end
    collect(0);
  endtask

  task automatic test_reset_mid_div();
    int seen;
    x_in = 16'h4500; y_in = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000 || flags !== 5'b0) begin
      $display("FAIL mid_reset: ov=%b ir=%b res=%h fl=%b required 0 1 0000 00000",
               out_valid, in_ready, result, flags);
      fails++;
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    asserts++;
    if (seen != 0) begin
      $display("FAIL mid_reset_ghost: out_valid high %0d cycles required 0", seen);
      fails++;
    end
    run_op("after_reset", 16'h3C00, 16'h3C00, 16'h3C00, 5'b0, NORM_LAT);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
